// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   arb_state_t           : arbiter FSM states
//   ARB_TIMEOUT_DATA      : read data returned to a port whose access timed out
//   ARB_MAX_SKIP_DEFAULT  : default consecutive data grants allowed over a pending fetch
//   ARB_TIMEOUT_DEFAULT   : default unacknowledged-access limit in cycles
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam logic [31:0] ARB_TIMEOUT_DATA     = 32'hDEAD_BEEF;
  localparam int unsigned ARB_MAX_SKIP_DEFAULT = 3;
  localparam int unsigned ARB_TIMEOUT_DEFAULT  = 64;

endpackage

// File: rtl/mem_arb_timer.sv
// Access timeout counter for mem_port_arbiter.
// Only compiled when MEM_PORT_ARB_TIMEOUT_EN is defined.
//   clk, reset : clock, asynchronous active-high reset
//   busy       : arbiter is in a BUSY state
//   ack        : memory acknowledged this cycle
//   expired    : this is the TIMEOUT-th BUSY cycle without an ack
`ifdef MEM_PORT_ARB_TIMEOUT_EN
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter holds the number of BUSY cycles already elapsed, so the current
  // cycle is number cnt_q+1; expiry fires on cycle TIMEOUT.
  always_comb begin
    cnt_d   = '0;
    expired = 1'b0;
    if (busy && !ack) begin
      cnt_d   = cnt_q + 1'b1;
      expired = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// instruction-fetch port (if_*) and the data port (dm_*).
// Data wins by default; after MAX_SKIP consecutive data grants taken while a
// fetch was waiting, the fetch is forced through.
// Optional feature: define MEM_PORT_ARB_TIMEOUT_EN to abort accesses that stay
// unacknowledged for TIMEOUT cycles (ready with 32'hDEADBEEF, sticky err).
//   clk, reset              : clock, asynchronous active-high reset
//   if_req/if_addr          : fetch request (held until if_ready)
//   if_rdata/if_ready       : fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request (held until dm_ready)
//   dm_rdata/dm_ready       : load data and one-cycle completion pulse
//   mem_valid/mem_we/mem_addr/mem_wdata : backing-memory request
//   mem_rdata/mem_ack       : backing-memory response
//   err                     : sticky timeout flag (0 when timeout compiled out)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_SKIP = ARB_MAX_SKIP_DEFAULT,
  parameter int unsigned TIMEOUT  = ARB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int unsigned SKIP_W = (MAX_SKIP < 3) ? 2 : $clog2(MAX_SKIP + 1);

  arb_state_t        state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              skip_full;
  logic              grant_dm;
  logic              grant_if;
  logic              timeout_hit;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  logic err_q, err_d;
  logic busy;

  assign busy = (state_q == BUSY_IF) || (state_q == BUSY_DM);

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy),
    .ack     (mem_ack),
    .expired (timeout_hit)
  );

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign skip_full = (skip_cnt_q == SKIP_W'(MAX_SKIP));
  assign grant_dm  = dm_req && !(if_req && skip_full);
  assign grant_if  = if_req && !grant_dm;

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d     = BUSY_DM;
          mem_valid_d = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req && !skip_full) begin
            skip_cnt_d = skip_cnt_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          skip_cnt_d  = '0;
        end
      end

      BUSY_IF, BUSY_DM: begin
        // An ack in the same cycle as expiry wins: the access did complete.
        if (mem_ack || timeout_hit) begin
          state_d     = DONE;
          mem_valid_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : ARB_TIMEOUT_DATA;
          end else begin
            dm_ready_d = 1'b1;
            if (!mem_ack) begin
              dm_rdata_d = ARB_TIMEOUT_DATA;
            end else if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
          if (!mem_ack) begin
            err_d = 1'b1;
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      skip_cnt_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Define MEM_PORT_ARB_TIMEOUT_EN to also exercise the timeout path (TIMEOUT=8).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int unsigned checks    = 0;
  int unsigned errors    = 0;
  int unsigned if_pulses = 0;
  int unsigned dm_pulses = 0;

  mem_port_arbiter #(
    .MAX_SKIP (3),
    .TIMEOUT  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_ready === 1'b1) if_pulses++;
    if (dm_ready === 1'b1) dm_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Acts as the backing memory for one access: waits (bounded) for mem_valid,
  // records the request, acks after lat BUSY cycles and returns at the DONE
  // cycle's falling edge. waited = falling edges spent before the grant.
  task automatic serve(input int unsigned lat, input logic [31:0] rd, input bit drop,
                       output logic [31:0] addr_s, output logic we_s,
                       output logic [31:0] wdata_s, output int unsigned waited);
    waited = 0;
    while (mem_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("grant_seen", {31'd0, mem_valid}, 32'd1);
    addr_s  = mem_addr;
    we_s    = mem_we;
    wdata_s = mem_wdata;
    if (drop) begin
      dm_req  = 1'b0;
      dm_addr = 32'hFFF0;
    end
    for (int unsigned i = 1; i < lat; i++) begin
      @(negedge clk);
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]  a;
    logic [31:0]  wd;
    logic         w;
    int unsigned  n;
    int unsigned  if_snap;
    int unsigned  dm_snap;
    logic [31:0]  exp_addr;

    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_addr",  mem_addr,           32'd0);
    check("rst_mem_wdata", mem_wdata,          32'd0);
    check("rst_if_ready",  {31'd0, if_ready},  32'd0);
    check("rst_dm_ready",  {31'd0, dm_ready},  32'd0);
    check("rst_if_rdata",  if_rdata,           32'd0);
    check("rst_dm_rdata",  dm_rdata,           32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, ack on the second BUSY cycle
    if_snap = if_pulses;
    dm_snap = dm_pulses;
    if_req  = 1'b1;
    if_addr = 32'h10;
    serve(2, 32'h00A0_0093, 1'b0, a, w, wd, n);
    check("fetch_addr",    a,                     32'h10);
    check("fetch_we",      {31'd0, w},            32'd0);
    check("fetch_latency", n,                     32'd1);
    check("fetch_ready",   {31'd0, if_ready},     32'd1);
    check("fetch_rdata",   if_rdata,              32'h00A0_0093);
    check("fetch_no_dm",   {31'd0, dm_ready},     32'd0);
    check("fetch_vld_low", {31'd0, mem_valid},    32'd0);
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("fetch_if_pulses", if_pulses - if_snap, 32'd1);
    check("fetch_dm_pulses", dm_pulses - dm_snap, 32'd0);

    // Store: rdata of the data port must not change
    if_snap  = if_pulses;
    dm_snap  = dm_pulses;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h100;
    dm_wdata = 32'h55;
    serve(2, 32'hCAFE_F00D, 1'b0, a, w, wd, n);
    check("store_addr",  a,                 32'h100);
    check("store_we",    {31'd0, w},        32'd1);
    check("store_wdata", wd,                32'h55);
    check("store_ready", {31'd0, dm_ready}, 32'd1);
    check("store_rdata", dm_rdata,          32'd0);
    check("store_no_if", {31'd0, if_ready}, 32'd0);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("store_dm_pulses", dm_pulses - dm_snap, 32'd1);
    check("store_if_pulses", if_pulses - if_snap, 32'd0);

    // Contention: both held, ack latency 1 -> DM,DM,DM,IF repeating, 3 cycles each
    if_addr = 32'h200;
    dm_addr = 32'h300;
    dm_we   = 1'b0;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      serve(1, 32'h1000 + k, 1'b0, a, w, wd, n);
      exp_addr = (k % 4 == 3) ? 32'h200 : 32'h300;
      check($sformatf("contend_grant_%0d", k), a, exp_addr);
      if (k > 0) check($sformatf("contend_gap_%0d", k), n, 32'd2);
      if (k % 4 == 3) begin
        check($sformatf("contend_ifrdy_%0d", k), {31'd0, if_ready}, 32'd1);
        check($sformatf("contend_ifdat_%0d", k), if_rdata, 32'h1000 + k);
      end else begin
        check($sformatf("contend_dmrdy_%0d", k), {31'd0, dm_ready}, 32'd1);
        check($sformatf("contend_dmdat_%0d", k), dm_rdata, 32'h1000 + k);
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);

    // Request dropped during BUSY_DM; address change after grant is ignored
    dm_snap = dm_pulses;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h40;
    serve(3, 32'h0000_1234, 1'b1, a, w, wd, n);
    check("drop_addr_at_grant", a,                 32'h40);
    check("drop_addr_held",     mem_addr,          32'h40);
    check("drop_ready",         {31'd0, dm_ready}, 32'd1);
    check("drop_rdata",         dm_rdata,          32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("drop_no_regrant_%0d", i), {31'd0, mem_valid}, 32'd0);
    end
    check("drop_dm_pulses", dm_pulses - dm_snap, 32'd1);

    // Reset during BUSY_IF, late ack after release is ignored
    if_snap = if_pulses;
    if_req  = 1'b1;
    if_addr = 32'h80;
    @(negedge clk);
    check("rstmid_busy", {31'd0, mem_valid}, 32'd1);
    reset  = 1'b1;
    if_req = 1'b0;
    #1;
    check("rstmid_valid_low", {31'd0, mem_valid}, 32'd0);
    check("rstmid_addr_clr",  mem_addr,           32'd0);
    check("rstmid_ifdat_clr", if_rdata,           32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rstmid_no_valid_%0d", i), {31'd0, mem_valid}, 32'd0);
      check($sformatf("rstmid_no_ready_%0d", i), {31'd0, if_ready},  32'd0);
      @(negedge clk);
    end
    check("rstmid_ifdat_kept", if_rdata,            32'd0);
    check("rstmid_if_pulses",  if_pulses - if_snap, 32'd0);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    // Timeout: no ack ever, 8 BUSY cycles then DONE with DEADBEEF and sticky err
    dm_snap = dm_pulses;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h20;
    n = 0;
    while (mem_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_grant", {31'd0, mem_valid}, 32'd1);
    n = 0;
    while (mem_valid === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_busy_cycles", n,                 32'd8);
    check("tmo_ready",       {31'd0, dm_ready}, 32'd1);
    check("tmo_rdata",       dm_rdata,          32'hDEAD_BEEF);
    check("tmo_err",         {31'd0, err},      32'd1);
    dm_req = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("tmo_err_sticky",  {31'd0, err},        32'd1);
    check("tmo_dm_pulses",   dm_pulses - dm_snap, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("tmo_err_cleared", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
`else
    check("err_tied_low", {31'd0, err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency backing memory between the pipeline's instruction-fetch port and the MEM-stage data port. The block sits between the CPU core's IF/MEM stages and the unified memory. It serialises requests through a small FSM and returns one-cycle ready pulses that the core uses to release its PC/IF-ID and EX-MEM stalls. The data port wins by default, and a bounded skip counter guarantees fetch progress.

## Interface
- MAX_SKIP, 3: consecutive data grants allowed while fetch is pending before fetch is forced.
- TIMEOUT, 64: cycles a memory access may stay unacknowledged (used only with the macro).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse.
- dm_req  in  1  data request, held until dm_ready.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data, valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse.
- mem_valid  out  1  backing-memory request, held until mem_ack.
- mem_we  out  1  write strobe.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  access complete.
- err  out  1  sticky timeout flag; constant 0 when timeout is compiled out.

## Operation
- States: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - With dm_req only, go to BUSY_DM.
  - With if_req only, go to BUSY_IF.
  - With both requests, go to BUSY_DM unless skip_cnt==MAX_SKIP, in which case go to BUSY_IF.
  - On entry to either BUSY state, latch the granted address, we and wdata into the mem_* registers. For fetch, mem_we=0.
- BUSY_*:
  - mem_valid=1.
  - On mem_ack, capture mem_rdata into the granted port's rdata register and go to DONE. A write returns rdata unchanged.
- DONE:
  - The granted port's ready=1 for exactly this cycle; mem_valid=0.
  - Requests are ignored in DONE. Go to IDLE.
- skip_cnt, 2+ bits, saturating:
  - Increments when BUSY_DM is granted while if_req=1.
  - Clears when BUSY_IF is granted.
- A request dropped mid-transaction does not abort it. The access completes and ready still pulses.
- Address and data inputs are sampled only at grant. Later changes are ignored until the next grant.
- A reset in the middle of a transaction immediately drives mem_valid low and returns the FSM to IDLE with all outputs at their reset values. Any mem_ack that arrives afterwards in IDLE is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - mem_valid, mem_we, if_ready, dm_ready and err are all 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata are all 0.
  - skip_cnt is 0.
- Latency: a request is seen at edge 0, mem_valid rises after edge 0, mem_ack is sampled at edge k, and ready is high for the cycle after edge k.
- Minimum access is 3 cycles (ack in the first BUSY cycle).
- Back-to-back throughput is 1 access per (ack latency + 2) cycles.
- All outputs are registered. There is no combinational path from mem_ack to ready.
- A requester must deassert req at the edge where it samples ready=1. The DONE cycle guarantees that request is not re-granted.

## Configuration
- MEM_PORT_ARB_TIMEOUT_EN, when defined:
  - A BUSY-state counter counts cycles without mem_ack.
  - When the count reaches TIMEOUT, drop mem_valid and go to DONE.
  - The granted port receives ready with rdata=32'hDEADBEEF.
  - err is set and stays set until reset.
- When undefined: no counter; BUSY waits indefinitely; err is tied to 0.

## Structure
- Shared package mem_arb_pkg holds:
  - the arb_state_t enum (IDLE/BUSY_IF/BUSY_DM/DONE);
  - the constants ARB_TIMEOUT_DATA=32'hDEADBEEF and default MAX_SKIP/TIMEOUT.
- Optional sub-module mem_arb_timer: the timeout counter, instantiated only under the macro.
- Everything else stays flat in mem_port_arbiter.

## Test plan
- Single fetch: if_req=1, if_addr=0x10, mem_ack on the 2nd BUSY cycle with mem_rdata=0x00A00093. Expect mem_addr=0x10, mem_we=0, one if_ready pulse with if_rdata=0x00A00093, and no dm_ready.
- Store: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0x55. Expect mem_we=1, mem_wdata=0x55, and a single dm_ready pulse. if_ready stays 0.
- Contention and fairness: if_req and dm_req held high continuously with MAX_SKIP=3 and ack latency 1. Expect grant order DM, DM, DM, IF, DM, DM, DM, IF, … and skip_cnt never above 3.
- Request drop: dm_req is deasserted during BUSY_DM. Expect the access to complete and one dm_ready pulse, then IDLE with no re-grant.
- Reset mid-access: reset asserted while in BUSY_IF, with mem_ack pulsed 2 cycles after release. Expect mem_valid=0 immediately, no if_ready, and the late ack ignored.
- Timeout (macro defined, TIMEOUT=8): mem_ack is never asserted. Expect mem_valid to drop after 8 BUSY cycles, the ready pulse with rdata=0xDEADBEEF, and err=1 held until reset.
